// File: rtl/pool_max_2x2.sv
// 2x2 stride-2 max pooling over a raster stream of binary16 values, half-width line buffer.
// Optional macro POOL_RELU_EN clamps every sample with the sign bit set (including -0) to +0 first.
module pool_max_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LD = IMG_WIDTH / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;

  // Map binary16 onto an unsigned key so one magnitude compare gives a total order (-0 < +0).
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (order_key(b) > order_key(a)) ? b : a;
  endfunction

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] lb_rd_q;
  logic [DATA_WIDTH-1:0] linebuf [LD];
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  load;
  logic [LW-1:0]         lb_idx;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] window_max;

`ifdef POOL_RELU_EN
  assign sample = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign sample = in_data;
`endif

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign col_last   = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last   = (row_q == RW'(IMG_HEIGHT - 1));
  assign lb_idx     = LW'(col_q >> 1);
  assign pair_max   = fmax(prev_q, sample);
  assign window_max = fmax(lb_rd_q, pair_max);
  assign load       = accept && row_q[0] && col_q[0];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = window_max;
      out_last_d  = row_last && col_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Datapath storage needs no reset: every entry is written before it is read in a frame.
  // The line buffer read is registered on the even column so the odd column finds it ready.
  always_ff @(posedge clk) begin
    if (accept && !col_q[0]) begin
      prev_q <= sample;
    end
    if (accept && !row_q[0] && col_q[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
    if (accept && row_q[0] && !col_q[0]) begin
      lb_rd_q <= linebuf[lb_idx];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_max_2x2.sv
// Scoreboard bench for pool_max_2x2 on a 4x4 image: directed frames, backpressure,
// mid-frame reset and back-to-back frames; monitor pops expected results on each transfer.
module tb_pool_max_2x2;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;

  always #5 clk = ~clk;

  pool_max_2x2 #(.DATA_WIDTH(16), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  typedef struct {
    logic [15:0] d;
    logic        l;
    int          c;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   prev_acc = 0;
  bit   have_prev = 1'b0;

  logic [15:0] frame_a [16] = '{
    16'h3C00, 16'h4000, 16'h4200, 16'h4400,
    16'h4500, 16'h3C00, 16'h3800, 16'h4600,
    16'hC000, 16'hBC00, 16'hC200, 16'hC400,
    16'hC500, 16'hC600, 16'hC700, 16'hC800};
  logic [15:0] frame_b [16] = '{
    16'h8000, 16'h8000, 16'h7C00, 16'h3C00,
    16'h0000, 16'h8000, 16'h7E00, 16'h0400,
    16'hFC00, 16'hFE00, 16'h0001, 16'h0000,
    16'hFC00, 16'hFC00, 16'h8001, 16'h3555};
`ifdef POOL_RELU_EN
  logic [15:0] exp_a [4] = '{16'h4500, 16'h4600, 16'h0000, 16'h0000};
  logic [15:0] exp_b [4] = '{16'h0000, 16'h7E00, 16'h0000, 16'h3555};
`else
  logic [15:0] exp_a [4] = '{16'h4500, 16'h4600, 16'hBC00, 16'hC200};
  logic [15:0] exp_b [4] = '{16'h0000, 16'h7E00, 16'hFC00, 16'h3555};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h, expected no output", out_data);
      end else begin
        e = sb_q.pop_front();
        $display("out cyc=%0d data=%h last=%b (expect %h last=%b)", cyc, out_data, out_last, e.d, e.l);
        check("out_data", {16'h0, out_data}, {16'h0, e.d});
        check("out_last", {31'h0, out_last}, {31'h0, e.l});
        if (e.c >= 0) check("out_latency", cyc, e.c);
      end
    end
  end

  // Called with inputs driven 1 time unit after a rising edge; returns in the same phase.
  task automatic send(input logic [15:0] d, input bit push, input logic [15:0] ed,
                      input logic el, input bit chk_lat);
    bit   done;
    exp_t e;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
        if (push) begin
          e.d = ed;
          e.l = el;
          e.c = chk_lat ? cyc + 1 : -1;
          sb_q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept of %h, expected accept within 100 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int sel, input bit bp, input bit b2b);
    int k;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] p;
      bit          is_out;
      p = (sel != 0) ? frame_b[i] : frame_a[i];
      is_out = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      if (is_out) begin
        send(p, 1'b1, (sel != 0) ? exp_b[k] : exp_a[k], (k == 3), !(bp && k == 0));
        k++;
      end else begin
        send(p, 1'b0, 16'h0000, 1'b0, 1'b0);
      end
      if (b2b) begin
        if (have_prev) check("b2b_gap", acc_cyc, prev_acc + 1);
        prev_acc  = acc_cyc;
        have_prev = 1'b1;
      end
      if (bp && i == 5) begin
        in_valid = 1'b1;
        in_data  = frame_a[6];
        repeat (3) begin
          @(negedge clk);
          check("bp_out_valid", {31'h0, out_valid}, 32'd1);
          check("bp_out_data", {16'h0, out_data}, {16'h0, exp_a[0]});
          check("bp_out_last", {31'h0, out_last}, 32'd0);
          check("bp_in_ready", {31'h0, in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("release_in_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    check("rst_out_last", {31'h0, out_last}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    send_frame(0, 1'b0, 1'b0);
    idle(2);
    send_frame(1, 1'b0, 1'b0);
    idle(2);

    out_ready = 1'b0;
    send_frame(0, 1'b1, 1'b0);
    idle(2);

    // Mid-frame reset with a result waiting in the output register.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(frame_a[i], 1'b0, 16'h0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", {31'h0, out_valid}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("mid_rst_out_data", {16'h0, out_data}, 32'h0);
    check("mid_rst_out_last", {31'h0, out_last}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_frame(0, 1'b0, 1'b0);
    idle(2);

    have_prev = 1'b0;
    send_frame(0, 1'b0, 1'b1);
    send_frame(1, 1'b0, 1'b1);
    idle(4);

    @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
